// File: rtl/mem_responder.sv
// Word-addressed scratchpad answering the accelerator memory request protocol,
// with programmable access latency and an independent host preload/readback port.
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_operation,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        mem_opdone,
  output logic        busy,
  output logic        err,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT    = 4'(LATENCY);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_wr;
  logic          r_oor;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_rsvd;
  logic          w_in_oor;
  logic          w_h_oor;
  logic [AW-1:0] w_h_idx;
  logic          w_commit;
  logic          w_c_wr;
  logic          w_c_oor;
  logic [AW-1:0] w_c_idx;
  logic [31:0]   w_c_data;

  assign w_req    = (r_state == S_IDLE) && mem_operation[0];
  assign w_rsvd   = (r_state == S_IDLE) && (mem_operation == 2'b10);
  assign w_in_oor = |addr_i[31:AW];
  assign w_h_oor  = |host_addr[31:AW];
  assign w_h_idx  = host_addr[AW-1:0];

  // Zero latency commits straight from the live inputs; otherwise from the latched request.
  always_comb begin
    w_commit = 1'b0;
    w_c_wr   = r_wr;
    w_c_oor  = r_oor;
    w_c_idx  = r_idx;
    w_c_data = r_wdata;
    if (r_state == S_IDLE) begin
      w_commit = w_req && (LATENCY == 0);
      w_c_wr   = mem_operation[1];
      w_c_oor  = w_in_oor;
      w_c_idx  = addr_i[AW-1:0];
      w_c_data = data_i;
    end else if (r_state == S_WAIT) begin
      w_commit = (r_cnt == 4'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_oor      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      data_o     <= '0;
      mem_opdone <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_rdata <= w_h_oor ? 32'd0 : r_mem[w_h_idx];
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_wr    <= mem_operation[1];
            r_oor   <= w_in_oor;
            r_idx   <= addr_i[AW-1:0];
            r_wdata <= data_i;
            r_cnt   <= LAT;
            busy    <= 1'b1;
            r_state <= (LATENCY == 0) ? S_DONE : S_WAIT;
          end else if (w_rsvd) begin
            err <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_DONE;
        end
        S_DONE: begin
          mem_opdone <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Read data is the pre-edge RAM word, so a colliding host write is not seen here.
      if (w_commit) begin
        mem_opdone <= 1'b1;
        if (w_c_oor) begin
          data_o <= 32'd0;
          err    <= 1'b1;
        end else begin
          data_o <= w_c_wr ? w_c_data : r_mem[w_c_idx];
        end
      end
    end
  end

  // Host write is ordered last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (w_commit && w_c_wr && !w_c_oor) r_mem[w_c_idx] <= w_c_data;
    if (host_we && !w_h_oor) r_mem[w_h_idx] <= host_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance per latency under test (1,0,3,15,4),
// table-driven single accesses plus hand sequences for streaming, collision and reset.
module tb_mem_responder;
  localparam int         N    = 5;
  localparam int         DEP  = 64;
  localparam logic [19:0] LATS = {4'd4, 4'd15, 4'd3, 4'd0, 4'd1};

  logic        clk;
  logic        reset_n;
  logic [1:0]  op   [N];
  logic [31:0] ad   [N];
  logic [31:0] di   [N];
  logic [31:0] dout [N];
  logic        done [N];
  logic        bsy  [N];
  logic        er   [N];
  logic        hwe  [N];
  logic [31:0] hadr [N];
  logic [31:0] hwd  [N];
  logic [31:0] hrd  [N];

  int n_vec = 0;
  int n_bad = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(.DEPTH(DEP), .LATENCY(int'(LATS[g*4 +: 4]))) u_dut (
      .clk(clk), .reset_n(reset_n), .mem_operation(op[g]), .addr_i(ad[g]),
      .data_i(di[g]), .data_o(dout[g]), .mem_opdone(done[g]), .busy(bsy[g]),
      .err(er[g]), .host_we(hwe[g]), .host_addr(hadr[g]), .host_wdata(hwd[g]),
      .host_rdata(hrd[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic host_wr(input int g, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    hwe[g] = 1'b1; hadr[g] = a; hwd[g] = d;
    @(negedge clk);
    hwe[g] = 1'b0;
  endtask

  task automatic host_rd(input string nm, input int g, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    hadr[g] = a;
    @(negedge clk);
    check(nm, hrd[g], exp);
  endtask

  // Request is driven in cycle C0; op drops to 00 right after so the latched request must finish alone.
  task automatic access(input string nm, input int g, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] d, input int lat,
                        output logic [31:0] dat, output logic erv);
    int  pk;
    bit  bsy_ok;
    pk = 0; bsy_ok = 1'b1; dat = '0; erv = 1'b0;
    @(negedge clk);
    op[g] = o; ad[g] = a; di[g] = d;
    for (int k = 1; k <= 40 && pk == 0; k++) begin
      @(negedge clk);
      if (k == 1) op[g] = 2'b00;
      if (!bsy[g]) bsy_ok = 1'b0;
      if (done[g]) begin
        pk = k; dat = dout[g]; erv = er[g];
      end
    end
    check({nm, " latency"}, 32'(pk), 32'(lat + 1));
    check({nm, " busy"}, 32'(bsy_ok), 32'd1);
    @(negedge clk);
    check({nm, " done low"}, 32'(done[g]), 32'd0);
    check({nm, " busy low"}, 32'(bsy[g]), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t        tv [9];
  logic [31:0] got;
  logic        gerr;
  logic [31:0] seq_exp [4];
  int          pulses;
  int          last_pk;

  initial begin
    tv[0] = '{2'b11, 32'd37, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0};
    tv[1] = '{2'b01, 32'd37, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tv[2] = '{2'b11, 32'd3,  32'h00000033, 1'b1, 32'h00000033, 1'b0};
    tv[3] = '{2'b11, 32'd63, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b0};
    tv[4] = '{2'b01, 32'd63, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0};
    tv[5] = '{2'b01, 32'd3,  32'h0,        1'b1, 32'h00000033, 1'b0};
    tv[6] = '{2'b01, DEP,    32'h0,        1'b1, 32'h0,        1'b1};
    tv[7] = '{2'b11, DEP+3,  32'hFFFF0000, 1'b0, 32'h0,        1'b1};
    tv[8] = '{2'b01, 32'd3,  32'h0,        1'b1, 32'h00000033, 1'b1};
    seq_exp[0] = 32'd4; seq_exp[1] = 32'd4; seq_exp[2] = 32'd2; seq_exp[3] = 32'd2;

    reset_n = 1'b0;
    for (int g = 0; g < N; g++) begin
      op[g] = 2'b00; ad[g] = '0; di[g] = '0; hwe[g] = 1'b0; hadr[g] = '0; hwd[g] = '0;
    end
    @(negedge clk);
    check("reset data_o", dout[0], 32'd0);
    check("reset flags", {29'd0, done[0], bsy[0], er[0]}, 32'd0);
    check("reset host_rdata", hrd[0], 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Preload 4,4,2,2 then stream reads, stepping addr_i on each pulse.
    for (int i = 0; i < 4; i++) host_wr(0, 32'(i), seq_exp[i]);
    @(negedge clk);
    op[0] = 2'b01; ad[0] = 32'd0;
    pulses = 0; last_pk = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done[0]) begin
        if (pulses < 4) check("stream data", dout[0], seq_exp[pulses]);
        check("stream spacing", 32'(k - last_pk), (pulses == 0) ? 32'd2 : 32'd3);
        last_pk = k;
        pulses++;
        ad[0] = 32'(pulses);
        if (pulses == 4) op[0] = 2'b00;
      end
    end
    check("stream pulse count", 32'(pulses), 32'd4);

    for (int i = 0; i < 9; i++) begin
      access($sformatf("vec%0d", i), 0, tv[i].op, tv[i].addr, tv[i].wdata, 1, got, gerr);
      if (tv[i].chk_data) check($sformatf("vec%0d data", i), got, tv[i].exp_data);
      check($sformatf("vec%0d err", i), 32'(gerr), 32'(tv[i].exp_err));
    end
    host_rd("host readback 37", 0, 32'd37, 32'hDEADBEEF);
    host_rd("host oor read", 0, 32'(DEP + 1), 32'd0);

    // Collision: host write to 9 on the initiator's commit edge.
    @(negedge clk);
    op[0] = 2'b11; ad[0] = 32'd9; di[0] = 32'h11;
    @(negedge clk);
    op[0] = 2'b00; hwe[0] = 1'b1; hadr[0] = 32'd9; hwd[0] = 32'h22;
    @(negedge clk);
    hwe[0] = 1'b0;
    check("collision done", 32'(done[0]), 32'd1);
    check("collision data_o", dout[0], 32'h11);
    host_rd("collision ram", 0, 32'd9, 32'h22);

    // Latency sweep on instances with LATENCY 0, 3, 15.
    for (int g = 1; g <= 3; g++) begin
      host_wr(g, 32'd5, 32'h55 + 32'(g));
      access($sformatf("sweep L%0d", int'(LATS[g*4 +: 4])), g, 2'b01, 32'd5, 32'h0,
             int'(LATS[g*4 +: 4]), got, gerr);
      check($sformatf("sweep%0d data", g), got, 32'h55 + 32'(g));
      check($sformatf("sweep%0d err", g), 32'(gerr), 32'd0);
    end

    // Reserved op: no pulse, sticky err.
    check("rsvd err before", 32'(er[1]), 32'd0);
    @(negedge clk);
    op[1] = 2'b10;
    @(negedge clk);
    op[1] = 2'b00;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (done[1] || bsy[1]) pulses++;
      @(negedge clk);
    end
    check("rsvd no pulse", 32'(pulses), 32'd0);
    check("rsvd err", 32'(er[1]), 32'd1);

    // Reset during WAIT of a write (LATENCY 4).
    host_wr(4, 32'd7, 32'h77);
    @(negedge clk);
    op[4] = 2'b11; ad[4] = 32'd7; di[4] = 32'hBAD;
    @(negedge clk);
    op[4] = 2'b00;
    @(negedge clk);
    check("pre-reset busy", 32'(bsy[4]), 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset busy", 32'(bsy[4]), 32'd0);
    check("reset done", 32'(done[4]), 32'd0);
    check("reset hrd", hrd[4], 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    host_rd("reset ram7", 4, 32'd7, 32'h77);
    access("post-reset read", 4, 2'b01, 32'd7, 32'h0, 4, got, gerr);
    check("post-reset data", got, 32'h77);
    check("post-reset err", 32'(gerr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed scratchpad memory that answers the accelerator-side memory request protocol (`mem_operation` / address / write data in, read data / `mem_opdone` out). It sits between the compute FSMs (convolution, matrix engines) and on-chip storage. It adds a programmable access latency and a host preload/readback port so firmware or a bench can place parameters and operands and collect results.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; power of two, 16..65536.
- `LATENCY`, 1: extra wait cycles per access, 0..15.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_operation` in 2: 01 read, 11 write, 00 none, 10 reserved.
- `addr_i` in 32: word address from initiator.
- `data_i` in 32: write data from initiator.
- `data_o` out 32: read data to initiator, valid while `mem_opdone`=1.
- `mem_opdone` out 1: one-cycle completion pulse per access.
- `busy` out 1: high while an initiator access is in flight, including the done cycle.
- `err` out 1: sticky; set by a reserved op or an out-of-range address; cleared only by reset.
- `host_we` in 1: host write strobe.
- `host_addr` in 32: host word address.
- `host_wdata` in 32: host write data.
- `host_rdata` out 32: registered read of `host_addr`, 1-cycle latency.

## Operation
- Reset (async assert, sync-safe deassert) drives `data_o`=0, `mem_opdone`=0, `busy`=0, `err`=0 and `host_rdata`=0, and puts the FSM in IDLE. RAM contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- **IDLE:**
  - If `mem_operation` is 01 or 11, latch `addr_i`, `data_i` and the op, load the counter with `LATENCY`, and set `busy`=1.
  - With `LATENCY`=0, go directly to DONE; otherwise go to WAIT.
  - 00 keeps the FSM in IDLE.
  - 10 keeps the FSM in IDLE and sets `err`.
- **WAIT:** decrement the counter. When it reaches 0, commit the access and go to DONE. Input changes during WAIT are ignored; the latched request completes even if `mem_operation` drops to 00.
- **Commit, on the edge entering DONE:**
  - Read: `data_o` <= RAM[idx].
  - Write: RAM[idx] <= latched data, and `data_o` <= latched data.
  - `mem_opdone` <= 1.
- **DONE:** lasts exactly one cycle. Then `mem_opdone` <= 0, `busy` <= 0, and the FSM returns to IDLE. Inputs are not sampled in DONE, because the initiator is still reacting to the pulse.
- **Index and range:**
  - idx = `addr_i`[log2(DEPTH)-1:0].
  - If `addr_i` >= DEPTH: a read returns 0, a write is dropped, `err` is set, and `mem_opdone` still pulses.
- `data_o` holds its last value outside DONE.
- **Host port:**
  - Independent of the FSM. It may write in any cycle; the write lands on the same edge.
  - `host_rdata` <= RAM[host idx] every cycle (read-before-write on a same-address host write).
  - An out-of-range host address gives a dropped write and `host_rdata`=0; `err` is not set.
- **Collision:** an initiator commit and a host write to the same index on the same edge leave the host value in RAM. `data_o` still returns the initiator's value: read data is the pre-edge contents, write echo is the initiator data.

## Timing
- Request visible in cycle C0: `mem_opdone`=1 in cycle C0+LATENCY+1, and low in C0+LATENCY+2.
- The next request is sampled at the end of C0+LATENCY+2 at the earliest.
- Back-to-back throughput is one access per LATENCY+2 cycles.
- An initiator that keeps `mem_operation`=01 and advances `addr_i` right after the pulse (sequential parameter fetch) gets exactly one pulse per address, and never a double pulse for a stale address.
- Reset asserted mid-WAIT or mid-DONE aborts the access immediately: a pending write is not committed and `mem_opdone` drops asynchronously.

## Test plan
- **Host preload, then read:** host writes 4, 4, 2, 2 to addresses 0..3. Initiator holds op=01 and steps `addr_i` 0→1→2→3 on each pulse (`LATENCY`=1). Required: exactly 4 pulses, each 3 cycles apart, with `data_o`=4, 4, 2, 2.
- **Write, then readback:** initiator writes 0xDEADBEEF to address 37. Required: `mem_opdone` 2 cycles after the request (`LATENCY`=1), and `host_rdata`=0xDEADBEEF one cycle after `host_addr`=37.
- **Latency sweep:** `LATENCY`=0, 3 and 15. Required: a read of address 5 pulses at C0+1, C0+4 and C0+16 respectively; `busy` is high from C0+1 through the pulse cycle.
- **Errors:** op=10 gives no pulse and `err`=1. A read of address DEPTH gives a pulse with `data_o`=0 and `err`=1. A write to DEPTH+3 leaves RAM unchanged.
- **Collision:** initiator writes 0x11 and host writes 0x22 to address 9, landing on the same edge. Required: RAM[9]=0x22 and `data_o`=0x11.
- **Reset mid-write:** assert `reset_n`=0 during WAIT of a write to address 7 (`LATENCY`=4). Required: outputs are 0 immediately, RAM[7] is unchanged, and after release a new read of address 7 works normally.
